// File: rtl/cpu_pkg.sv
// Shared MIPS CPU definitions: opcode constants, the bubble instruction and the fetch FSM states.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SH    = 6'b101001;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // sll $0,$0,0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_stage_if.sv
// Instruction-memory request/ready bus between the fetch stage (master) and memory (slave).
interface instr_fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ready, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ready, imem_rdata);
endinterface

// File: rtl/instr_fetch_stage_pc_select.sv
// Combinational next-PC selection: sequential PC+4, branch/jump redirect target,
// and the resume address used when a pending redirect completes.
module fetch_pc_select (
  input  logic [31:0] pc,
  input  logic [31:0] if_id_pc4,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic [31:0] redirect_pc,
  output logic        redirect,
  output logic [31:0] pc_plus4,
  output logic [31:0] target,
  output logic [31:0] resume_pc
);

  assign redirect = jump | branch_taken;
  assign pc_plus4 = pc + 32'd4;

  // Jump wins over a simultaneous taken branch; targets are forced word-aligned.
  always_comb begin
    if (jump) target = {if_id_pc4[31:28], jump_index, 2'b00};
    else      target = {branch_target[31:2], 2'b00};
  end

  // A redirect arriving while one is pending replaces it.
  assign resume_pc = redirect ? target : redirect_pc;

endmodule

// File: rtl/instr_fetch_stage.sv
// MIPS IF stage with IF/ID register, decode stall, one-entry hold buffer and stale-fetch discard.
// Optional macro IF_DELAY_SLOT_EN keeps the in-flight fetch after a redirect (branch delay slot).
module instr_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall,
  input  logic                       branch_taken,
  input  logic [31:0]                branch_target,
  input  logic                       jump,
  input  logic [25:0]                jump_index,
  instr_fetch_stage_if.master        imem,
  output logic [31:0]                if_id_instr,
  output logic [31:0]                if_id_pc4,
  output logic                       if_id_valid,
  output logic [5:0]                 opcode
);
  import cpu_pkg::*;

`ifdef IF_DELAY_SLOT_EN
  localparam bit DELAY_SLOT = 1'b1;
`else
  localparam bit DELAY_SLOT = 1'b0;
`endif

  fetch_state_t state, state_d;
  logic [31:0]  pc, pc_d;
  logic [31:0]  instr_d, pc4_d;
  logic         valid_d;
  logic [31:0]  buf_instr, buf_instr_d, buf_pc4, buf_pc4_d;
  logic [31:0]  redirect_pc, redirect_pc_d;
  logic         redirect;
  logic [31:0]  pc_plus4, target, resume_pc;

  fetch_pc_select u_pc_select (
    .pc            (pc),
    .if_id_pc4     (if_id_pc4),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_index    (jump_index),
    .redirect_pc   (redirect_pc),
    .redirect      (redirect),
    .pc_plus4      (pc_plus4),
    .target        (target),
    .resume_pc     (resume_pc)
  );

  assign imem.imem_addr = pc;
  assign opcode         = if_id_instr[31:26];

  always_comb begin
    state_d       = state;
    pc_d          = pc;
    instr_d       = if_id_instr;
    pc4_d         = if_id_pc4;
    valid_d       = if_id_valid;
    buf_instr_d   = buf_instr;
    buf_pc4_d     = buf_pc4;
    redirect_pc_d = redirect_pc;
    imem.imem_req = 1'b0;

    case (state)
      FETCH: begin
        imem.imem_req = 1'b1;
        if (redirect && !DELAY_SLOT) begin
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
          if (imem.imem_ready) begin
            pc_d = target;
          end else begin
            // pc stays put so the outstanding address remains stable
            redirect_pc_d = target;
            state_d       = DISCARD;
          end
        end else if (imem.imem_ready) begin
          if (stall) begin
            buf_instr_d = imem.imem_rdata;
            buf_pc4_d   = pc_plus4;
            state_d     = HOLD;
          end else begin
            instr_d = imem.imem_rdata;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
          end
          pc_d = redirect ? target : pc_plus4;
        end else begin
          if (!stall) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
          end
          if (redirect) begin
            redirect_pc_d = target;
            state_d       = DISCARD;
          end
        end
      end

      HOLD: begin
        if (redirect) pc_d = target;
        if (redirect && !DELAY_SLOT) begin
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
          state_d = FETCH;
        end else if (!stall) begin
          instr_d = buf_instr;
          pc4_d   = buf_pc4;
          valid_d = 1'b1;
          state_d = FETCH;
        end
      end

      DISCARD: begin
        imem.imem_req = 1'b1;
        if (redirect) redirect_pc_d = target;
        if (DELAY_SLOT) begin
          // Redirect pending: the slot response is captured like a normal fetch.
          if (imem.imem_ready) begin
            if (stall) begin
              buf_instr_d = imem.imem_rdata;
              buf_pc4_d   = pc_plus4;
              state_d     = HOLD;
            end else begin
              instr_d = imem.imem_rdata;
              pc4_d   = pc_plus4;
              valid_d = 1'b1;
              state_d = FETCH;
            end
            pc_d = resume_pc;
          end else if (!stall) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
          end
        end else begin
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
          if (imem.imem_ready) begin
            pc_d    = resume_pc;
            state_d = FETCH;
          end
        end
      end

      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      if_id_instr <= NOP_INSTR;
      if_id_pc4   <= '0;
      if_id_valid <= 1'b0;
      buf_instr   <= NOP_INSTR;
      buf_pc4     <= '0;
      redirect_pc <= '0;
    end else begin
      pc          <= pc_d;
      if_id_instr <= instr_d;
      if_id_pc4   <= pc4_d;
      if_id_valid <= valid_d;
      buf_instr   <= buf_instr_d;
      buf_pc4     <= buf_pc4_d;
      redirect_pc <= redirect_pc_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Self-checking bench for instr_fetch_stage: directed table, redirect sequences, random vs reference model.
module tb_instr_fetch_stage;
  import cpu_pkg::*;

`ifdef IF_DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, stall, branch_taken, jump, ready;
  logic [31:0] branch_target;
  logic [25:0] jump_index;
  logic [31:0] if_id_instr, if_id_pc4;
  logic        if_id_valid;
  logic [5:0]  opcode;
  int          checks = 0;
  int          errors = 0;

  instr_fetch_stage_if bus ();

  always #5 clk = ~clk;

  // Memory content is a pure function of the address so every fetch is identifiable.
  function automatic logic [31:0] word(input logic [31:0] a);
    return ~a;
  endfunction

  assign bus.imem_rdata = word(bus.imem_addr);
  assign bus.imem_ready = ready;

  instr_fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP_INSTR)) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_index    (jump_index),
    .imem          (bus.master),
    .if_id_instr   (if_id_instr),
    .if_id_pc4     (if_id_pc4),
    .if_id_valid   (if_id_valid),
    .opcode        (opcode)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string t, input logic req, input logic [31:0] addr,
                         input logic [31:0] instr, input logic [31:0] pc4, input logic v);
    logic [31:0] e_instr;
    e_instr = instr;
    chk({t, ".req"},    32'(bus.imem_req), 32'(req));
    chk({t, ".addr"},   bus.imem_addr,     addr);
    chk({t, ".instr"},  if_id_instr,       instr);
    chk({t, ".pc4"},    if_id_pc4,         pc4);
    chk({t, ".valid"},  32'(if_id_valid),  32'(v));
    chk({t, ".opcode"}, 32'(opcode),       32'(e_instr[31:26]));
  endtask

  // Drive inputs away from the edge, let one clock edge happen, sample just after it.
  task automatic step(input logic r, input logic s, input logic rdy, input logic br,
                      input logic [31:0] bt, input logic j, input logic [25:0] ji);
    @(negedge clk);
    reset = r; stall = s; ready = rdy; branch_taken = br;
    branch_target = bt; jump = j; jump_index = ji;
    @(posedge clk);
    #1;
  endtask

  // Reference model: PC, IF/ID record, a hold queue (cap 1) and a queue of pending redirect targets.
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid;
  logic [31:0] hold_instr_q[$];
  logic [31:0] hold_pc4_q[$];
  logic [31:0] pend_q[$];

  task automatic model(input logic r, input logic s, input logic rdy, input logic br,
                       input logic [31:0] bt, input logic j, input logic [25:0] ji);
    logic [31:0] tgt;
    logic        redir, drop;
    redir = br | j;
    tgt   = j ? {m_pc4[31:28], ji, 2'b00} : {bt[31:2], 2'b00};
    if (r) begin
      m_pc = 32'h0; m_instr = NOP_INSTR; m_pc4 = 32'h0; m_valid = 1'b0;
      hold_instr_q.delete(); hold_pc4_q.delete(); pend_q.delete();
    end else if (hold_instr_q.size() != 0) begin
      if (redir) m_pc = tgt;
      if (redir && !DS) begin
        hold_instr_q.delete(); hold_pc4_q.delete();
        m_instr = NOP_INSTR; m_valid = 1'b0;
      end else if (!s) begin
        m_instr = hold_instr_q.pop_front();
        m_pc4   = hold_pc4_q.pop_front();
        m_valid = 1'b1;
      end
    end else begin
      drop = !DS && (redir || pend_q.size() != 0);
      if (redir) pend_q = '{tgt};
      if (rdy) begin
        if (!drop) begin
          if (s) begin
            hold_instr_q.push_back(word(m_pc));
            hold_pc4_q.push_back(m_pc + 32'd4);
          end else begin
            m_instr = word(m_pc); m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
          end
        end
        m_pc = (pend_q.size() != 0) ? pend_q[0] : m_pc + 32'd4;
        pend_q.delete();
      end else if (!drop && !s) begin
        m_instr = NOP_INSTR; m_valid = 1'b0;
      end
      if (drop) begin
        m_instr = NOP_INSTR; m_valid = 1'b0;
      end
    end
  endtask

  typedef struct {
    logic        rst, stl, rdy;
    logic        req;
    logic [31:0] addr, instr, pc4;
    logic        v;
  } vec_t;

  vec_t tbl[16];

  initial begin
    reset = 1'b1; stall = 1'b0; ready = 1'b0; branch_taken = 1'b0;
    branch_target = '0; jump = 1'b0; jump_index = '0;

    // Zero-wait fetch, 3-cycle stall into HOLD at pc=8, ready every third cycle, reset in HOLD.
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h00, 32'h0000_0000, 32'h00, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h04, 32'hFFFF_FFFF, 32'h04, 1'b1};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h08, 32'hFFFF_FFFB, 32'h08, 1'b1};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0C, 32'hFFFF_FFFB, 32'h08, 1'b1};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0C, 32'hFFFF_FFFB, 32'h08, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0C, 32'hFFFF_FFFB, 32'h08, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0C, 32'hFFFF_FFF7, 32'h0C, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0C, 32'h0000_0000, 32'h0C, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0C, 32'h0000_0000, 32'h0C, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h10, 32'hFFFF_FFF3, 32'h10, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h10, 32'h0000_0000, 32'h10, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h10, 32'h0000_0000, 32'h10, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h14, 32'hFFFF_FFEF, 32'h14, 1'b1};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h14, 32'hFFFF_FFEF, 32'h14, 1'b1};
    tbl[14] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h18, 32'hFFFF_FFEF, 32'h14, 1'b1};
    tbl[15] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h00, 32'h0000_0000, 32'h00, 1'b0};

    for (int i = 0; i < 16; i++) begin
      step(tbl[i].rst, tbl[i].stl, tbl[i].rdy, 1'b0, 32'h0, 1'b0, 26'h0);
      chk_out($sformatf("vec%0d", i), tbl[i].req, tbl[i].addr, tbl[i].instr, tbl[i].pc4, tbl[i].v);
    end

    // Branch to 0x40 while the fetch at 0x10 waits.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 26'h0);
    chk_out("br.pre", 1'b1, 32'h10, 32'hFFFF_FFF3, 32'h10, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 26'h0);
    chk_out("br.req", 1'b1, 32'h10, 32'h0, 32'h10, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
    chk_out("br.wait", 1'b1, 32'h10, 32'h0, 32'h10, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 26'h0);
    chk_out("br.slot", 1'b1, 32'h40, DS ? 32'hFFFF_FFEF : 32'h0, DS ? 32'h14 : 32'h10, DS);
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 26'h0);
    chk_out("br.tgt", 1'b1, 32'h44, 32'hFFFF_FFBF, 32'h44, 1'b1);

    // Reset while a redirect is pending.
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h80, 1'b0, 26'h0);
    chk_out("rst.disc.pre", 1'b1, 32'h44, 32'h0, 32'h44, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
    chk_out("rst.disc", 1'b1, 32'h0, 32'h0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 26'h0);
    chk_out("rst.disc.post", 1'b1, 32'h4, 32'hFFFF_FFFF, 32'h4, 1'b1);

    // Jump concatenation from if_id_pc4 = 0x1000_0008; jump wins over a simultaneous branch.
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h1000_0004, 1'b0, 26'h0);
    chk("jmp.setup.addr", bus.imem_addr, 32'h1000_0004);
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 26'h0);
    chk_out("jmp.pre", 1'b1, 32'h1000_0008, 32'hEFFF_FFFB, 32'h1000_0008, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h200, 1'b1, 26'h000_0010);
    chk_out("jmp", 1'b1, 32'h1000_0040, DS ? 32'hEFFF_FFF7 : 32'h0,
            DS ? 32'h1000_000C : 32'h1000_0008, DS);

    // PC+4 wrap.
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 26'h0);
    chk("wrap.pre.addr", bus.imem_addr, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 26'h0);
    chk_out("wrap", 1'b1, 32'h0, 32'h0000_0003, 32'h0, 1'b1);

    // Randomized traffic against the reference model.
    model(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
    chk_out("rand.rst", 1'b1, m_pc, m_instr, m_pc4, m_valid);
    for (int n = 0; n < 3000; n++) begin
      logic        r, s, rdy, br, j;
      logic [31:0] bt;
      logic [25:0] ji;
      r   = ($urandom_range(99) < 2);
      s   = ($urandom_range(99) < 30);
      rdy = 1'($urandom_range(1));
      br  = ($urandom_range(99) < 10);
      j   = ($urandom_range(99) < 5);
      bt  = $urandom;
      ji  = 26'($urandom);
      model(r, s, rdy, br, bt, j, ji);
      step(r, s, rdy, br, bt, j, ji);
      chk_out($sformatf("rand%0d", n), hold_instr_q.size() == 0, m_pc, m_instr, m_pc4, m_valid);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
